// File: rtl/muldiv_pkg.sv
// -----------------------------------------------------------------------------
// muldiv_pkg
//   Shared definitions for the iterative RV32M/RV64M multiply/divide unit:
//   funct3 operation encodings, FSM state encodings and small decode helpers
//   describing the signedness and class of each operation.
// -----------------------------------------------------------------------------
package muldiv_pkg;

   // funct3 encodings of the M-extension operations
   typedef enum logic [2:0] {
      MD_MUL    = 3'd0,
      MD_MULH   = 3'd1,
      MD_MULHSU = 3'd2,
      MD_MULHU  = 3'd3,
      MD_DIV    = 3'd4,
      MD_DIVU   = 3'd5,
      MD_REM    = 3'd6,
      MD_REMU   = 3'd7
   } md_op_e;

   // Engine sequencing states
   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_CALC  = 2'd1,
      ST_FIXUP = 2'd2,
      ST_DONE  = 2'd3
   } md_state_e;

   // Divide and remainder operations share funct3[2]
   function automatic logic op_is_div(input md_op_e op);
      return op[2];
   endfunction

   function automatic logic op_is_rem(input md_op_e op);
      return (op == MD_REM) || (op == MD_REMU);
   endfunction

   // rs1 is interpreted as signed
   function automatic logic op_a_signed(input md_op_e op);
      return (op == MD_MULH) || (op == MD_MULHSU) || (op == MD_DIV) || (op == MD_REM);
   endfunction

   // rs2 is interpreted as signed
   function automatic logic op_b_signed(input md_op_e op);
      return (op == MD_MULH) || (op == MD_DIV) || (op == MD_REM);
   endfunction

endpackage

// File: rtl/muldiv_iter_step.sv
// -----------------------------------------------------------------------------
// muldiv_iter_step
//   Combinational BPC-bit iteration shared by multiply and divide. Both use a
//   2*XLEN accumulator {hi, lo}:
//     multiply : hi = partial product, lo = remaining multiplier bits;
//                m_i is the multiplicand.
//     divide   : hi = partial remainder, lo = dividend shifting out / quotient
//                shifting in; m_i is the divisor (restoring algorithm).
// Ports
//   is_div_i  select restoring-divide step instead of shift-add step
//   acc_i     current accumulator
//   m_i       multiplicand or divisor magnitude
//   acc_o     accumulator after BPC bits of work
// -----------------------------------------------------------------------------
module muldiv_iter_step
   import muldiv_pkg::*;
#(
   parameter int XLEN = 32,
   parameter int BPC  = 1
) (
   input  logic              is_div_i,
   input  logic [2*XLEN-1:0] acc_i,
   input  logic [XLEN-1:0]   m_i,
   output logic [2*XLEN-1:0] acc_o
);

   logic [BPC-1:0]         digit_s;
   logic [XLEN+BPC-1:0]    pprod_s;
   logic [XLEN+BPC-1:0]    sum_s;
   logic [2*XLEN+BPC-1:0]  mul_ext_s;
   logic [2*XLEN-1:0]      mul_res_s;
   logic [XLEN-1:0]        rem_s;
   logic [XLEN-1:0]        quo_s;
   logic [XLEN:0]          trial_s;
   logic [XLEN:0]          diff_s;

   // Shift-add: add multiplicand*digit into the high half, then shift right
   // by BPC; the carry bits of the sum land at the top of the new high half.
   always_comb begin
      digit_s   = acc_i[BPC-1:0];
      pprod_s   = {{BPC{1'b0}}, m_i} * {{XLEN{1'b0}}, digit_s};
      sum_s     = {{BPC{1'b0}}, acc_i[2*XLEN-1:XLEN]} + pprod_s;
      mul_ext_s = {sum_s, acc_i[XLEN-1:0]};
      mul_res_s = mul_ext_s[2*XLEN+BPC-1:BPC];
   end

   // Restoring division, one quotient bit per inner iteration
   always_comb begin
      rem_s   = acc_i[2*XLEN-1:XLEN];
      quo_s   = acc_i[XLEN-1:0];
      trial_s = {(XLEN+1){1'b0}};
      diff_s  = {(XLEN+1){1'b0}};
      for (int i = 0; i < BPC; i++) begin
         trial_s = {rem_s, quo_s[XLEN-1]};
         quo_s   = {quo_s[XLEN-2:0], 1'b0};
         diff_s  = trial_s - {1'b0, m_i};
         if (trial_s >= {1'b0, m_i}) begin
            // partial remainder < divisor, so the difference fits in XLEN bits
            rem_s    = diff_s[XLEN-1:0];
            quo_s[0] = 1'b1;
         end else begin
            rem_s    = trial_s[XLEN-1:0];
         end
      end
   end

   // Result select
   always_comb begin
      if (is_div_i) begin
         acc_o = {rem_s, quo_s};
      end else begin
         acc_o = mul_res_s;
      end
   end

endmodule

// File: rtl/muldiv_unit.sv
// -----------------------------------------------------------------------------
// muldiv_unit
//   Iterative RV32M/RV64M multiply/divide engine with valid/ready handshakes.
//   FSM IDLE -> CALC (XLEN/BPC cycles) -> FIXUP -> DONE -> IDLE; division by
//   zero and signed overflow bypass CALC and go straight to DONE.
// Ports
//   clk, rst         clock (rising edge), asynchronous active-high reset
//   flush            abort any in-flight op; dominates all other inputs
//   in_valid/ready   request handshake (ready only while IDLE)
//   in_op/a/b/tag    funct3, rs1, rs2 and destination tag
//   out_valid/ready  result handshake; result held until accepted
//   out_res/out_tag  result and the tag of the op that produced it
//   busy             engine not IDLE
// -----------------------------------------------------------------------------
module muldiv_unit
   import muldiv_pkg::*;
#(
   parameter int XLEN  = 32,
   parameter int BPC   = 1,
   parameter int TAG_W = 5
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             flush,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [2:0]       in_op,
   input  logic [XLEN-1:0]  in_a,
   input  logic [XLEN-1:0]  in_b,
   input  logic [TAG_W-1:0] in_tag,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [XLEN-1:0]  out_res,
   output logic [TAG_W-1:0] out_tag,
   output logic             busy
);

   localparam int N     = XLEN / BPC;
   localparam int CNT_W = (N > 1) ? $clog2(N) : 1;
   localparam logic [XLEN-1:0] MIN_NEG  = {1'b1, {(XLEN-1){1'b0}}};
   localparam logic [XLEN-1:0] ALL_ONES = {XLEN{1'b1}};

   md_state_e         state_q;
   md_op_e            op_q;
   logic [TAG_W-1:0]  tag_q;
   logic              neg_q;
   logic [CNT_W-1:0]  cnt_q;
   logic [XLEN-1:0]   m_q;
   logic [2*XLEN-1:0] acc_q;
   logic [2*XLEN-1:0] acc_d;
   logic [XLEN-1:0]   res_q;
   logic [TAG_W-1:0]  res_tag_q;

   md_op_e            op_s;
   logic              a_neg_s;
   logic              b_neg_s;
   logic              res_neg_s;
   logic [XLEN-1:0]   a_mag_s;
   logic [XLEN-1:0]   b_mag_s;
   logic [XLEN-1:0]   m_init_s;
   logic [2*XLEN-1:0] acc_init_s;
   logic              special_s;
   logic [XLEN-1:0]   special_res_s;
   logic [2*XLEN-1:0] prod_fix_s;
   logic [XLEN-1:0]   lo_fix_s;
   logic [XLEN-1:0]   hi_fix_s;
   logic [XLEN-1:0]   fix_res_s;

   assign op_s = md_op_e'(in_op);

   // Operand magnitudes, result sign and initial engine operands
   always_comb begin
      a_neg_s = op_a_signed(op_s) & in_a[XLEN-1];
      b_neg_s = op_b_signed(op_s) & in_b[XLEN-1];
      if (a_neg_s) begin
         a_mag_s = {XLEN{1'b0}} - in_a;
      end else begin
         a_mag_s = in_a;
      end
      if (b_neg_s) begin
         b_mag_s = {XLEN{1'b0}} - in_b;
      end else begin
         b_mag_s = in_b;
      end
      // remainder follows the dividend; everything else follows the product sign
      if (op_is_rem(op_s)) begin
         res_neg_s = a_neg_s;
      end else begin
         res_neg_s = a_neg_s ^ b_neg_s;
      end
      if (op_is_div(op_s)) begin
         m_init_s   = b_mag_s;
         acc_init_s = {{XLEN{1'b0}}, a_mag_s};
      end else begin
         m_init_s   = a_mag_s;
         acc_init_s = {{XLEN{1'b0}}, b_mag_s};
      end
   end

   // Division by zero and signed overflow resolve without iterating
   always_comb begin
      special_s     = 1'b0;
      special_res_s = {XLEN{1'b0}};
      if (op_is_div(op_s) && (in_b == {XLEN{1'b0}})) begin
         special_s = 1'b1;
         if (op_is_rem(op_s)) begin
            special_res_s = in_a;
         end else begin
            special_res_s = ALL_ONES;
         end
      end else if (((op_s == MD_DIV) || (op_s == MD_REM)) &&
                   (in_a == MIN_NEG) && (in_b == ALL_ONES)) begin
         special_s = 1'b1;
         if (op_s == MD_REM) begin
            special_res_s = {XLEN{1'b0}};
         end else begin
            special_res_s = in_a;
         end
      end else begin
         special_s     = 1'b0;
         special_res_s = {XLEN{1'b0}};
      end
   end

   // Sign correction and half selection applied in FIXUP
   always_comb begin
      if (neg_q) begin
         prod_fix_s = {(2*XLEN){1'b0}} - acc_q;
         lo_fix_s   = {XLEN{1'b0}} - acc_q[XLEN-1:0];
         hi_fix_s   = {XLEN{1'b0}} - acc_q[2*XLEN-1:XLEN];
      end else begin
         prod_fix_s = acc_q;
         lo_fix_s   = acc_q[XLEN-1:0];
         hi_fix_s   = acc_q[2*XLEN-1:XLEN];
      end
      case (op_q)
         MD_MUL:                       fix_res_s = acc_q[XLEN-1:0];
         MD_MULH, MD_MULHSU, MD_MULHU: fix_res_s = prod_fix_s[2*XLEN-1:XLEN];
         MD_DIV, MD_DIVU:              fix_res_s = lo_fix_s;
         MD_REM, MD_REMU:              fix_res_s = hi_fix_s;
         default:                      fix_res_s = {XLEN{1'b0}};
      endcase
   end

   muldiv_iter_step #(
      .XLEN (XLEN),
      .BPC  (BPC)
   ) u_step (
      .is_div_i (op_is_div(op_q)),
      .acc_i    (acc_q),
      .m_i      (m_q),
      .acc_o    (acc_d)
   );

   // Main FSM, iteration counter, operand capture and output registers
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q   <= ST_IDLE;
         op_q      <= MD_MUL;
         tag_q     <= {TAG_W{1'b0}};
         neg_q     <= 1'b0;
         cnt_q     <= {CNT_W{1'b0}};
         m_q       <= {XLEN{1'b0}};
         acc_q     <= {(2*XLEN){1'b0}};
         res_q     <= {XLEN{1'b0}};
         res_tag_q <= {TAG_W{1'b0}};
      end else if (flush) begin
         state_q <= ST_IDLE;
      end else begin
         case (state_q)
            ST_IDLE: begin
               if (in_valid) begin
                  op_q  <= op_s;
                  tag_q <= in_tag;
                  neg_q <= res_neg_s;
                  if (special_s) begin
                     res_q     <= special_res_s;
                     res_tag_q <= in_tag;
                     state_q   <= ST_DONE;
                  end else begin
                     m_q     <= m_init_s;
                     acc_q   <= acc_init_s;
                     cnt_q   <= CNT_W'(N - 1);
                     state_q <= ST_CALC;
                  end
               end
            end
            ST_CALC: begin
               acc_q <= acc_d;
               if (cnt_q == {CNT_W{1'b0}}) begin
                  state_q <= ST_FIXUP;
               end else begin
                  cnt_q <= cnt_q - {{(CNT_W-1){1'b0}}, 1'b1};
               end
            end
            ST_FIXUP: begin
               res_q     <= fix_res_s;
               res_tag_q <= tag_q;
               state_q   <= ST_DONE;
            end
            ST_DONE: begin
               if (out_ready) begin
                  state_q <= ST_IDLE;
               end
            end
            default: state_q <= ST_IDLE;
         endcase
      end
   end

   assign in_ready  = (state_q == ST_IDLE);
   assign busy      = (state_q != ST_IDLE);
   assign out_valid = (state_q == ST_DONE);
   assign out_res   = res_q;
   assign out_tag   = res_tag_q;

endmodule
